// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types and defaults for the IFU->IDU0 fetch queue.
package fetch_queue_pkg;
    localparam int INSTR_LEN         = 32;
    localparam int XLEN              = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      tag;
    } fq_entry_t;
endpackage

// File: rtl/fq_regfile.sv
// fq_regfile: DEPTH-entry flop array, one write port, one asynchronous read port.
// Data is deliberately not reset; validity is tracked by the queue counter.
module fq_regfile
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  fq_entry_t                i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output fq_entry_t                o_rdata
);
    fq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between IFU and IDU0, in-order, flushed on redirect.
// Optional same-cycle forwarding into an empty queue with FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    parameter int SKID  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [INSTR_LEN-1:0]       instr_in,
    input  logic                       instr_valid_in,
    input  logic [XLEN-1:0]            instr_tag_in,
    output logic                       fq_ready,
    output logic [INSTR_LEN-1:0]       instr,
    output logic                       instr_valid,
    output logic [XLEN-1:0]            instr_tag,
    input  logic                       pipe_stall,
    output logic [$clog2(DEPTH):0]     fq_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ready_en;
    fq_entry_t     w_wdata, w_head, w_out;
    logic          w_push, w_pop, w_bypass;

    assign w_wdata = '{instr: instr_in, tag: instr_tag_in};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = (r_count == '0) && instr_valid_in && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed instruction consumed by IDU0 this cycle never enters the array.
    assign w_push = instr_valid_in && (r_count < CW'(DEPTH)) && !flush && !(w_bypass && !pipe_stall);
    assign w_pop  = (r_count != '0) && !pipe_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(instr_valid_in && !flush && r_count == CW'(DEPTH)));
    end

    fq_regfile #(.DEPTH(DEPTH)) u_regfile (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign w_out       = w_bypass ? w_wdata : w_head;
    assign instr_valid = (r_count != '0) || w_bypass;
    assign instr       = instr_valid ? w_out.instr : '0;
    assign instr_tag   = instr_valid ? w_out.tag : '0;
    assign fq_count    = r_count;
    assign fq_ready    = r_ready_en && (int'(r_count) + SKID < DEPTH) && !flush;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (DEPTH=4, SKID=1, default build).
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_in = '0;
    logic        instr_valid_in = 1'b0;
    logic [31:0] instr_tag_in = '0;
    logic        pipe_stall = 1'b0;
    logic        fq_ready, instr_valid;
    logic [31:0] instr, instr_tag;
    logic [2:0]  fq_count;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] sb [$];

    fetch_queue #(.DEPTH(4), .SKID(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .instr_in       (instr_in),
        .instr_valid_in (instr_valid_in),
        .instr_tag_in   (instr_tag_in),
        .fq_ready       (fq_ready),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_tag      (instr_tag),
        .pipe_stall     (pipe_stall),
        .fq_count       (fq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Drive one cycle, check outputs mid-cycle against the scoreboard, then update it.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                        input logic st, input logic fl);
        int n;
        instr_valid_in = v;
        instr_in       = ins;
        instr_tag_in   = tg;
        pipe_stall     = st;
        flush          = fl;
        @(negedge clk);
        n = sb.size();
        chk("valid", 64'(instr_valid), 64'(n != 0));
        chk("count", 64'(fq_count), 64'(n));
        chk("ready", 64'(fq_ready), 64'((n + 1 < 4) && !fl));
        if (n != 0) begin
            chk("instr", 64'(instr), 64'(sb[0][63:32]));
            chk("tag", 64'(instr_tag), 64'(sb[0][31:0]));
        end
        if (fl) sb.delete();
        else begin
            if (n != 0 && !st) void'(sb.pop_front());
            if (v && n < 4) sb.push_back({ins, tg});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_count", 64'(fq_count), 64'd0);
        chk("rst_ready", 64'(fq_ready), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(fq_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("post_ready", 64'(fq_ready), 64'd1);

        step(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) step(1'b1, 32'hA000_0000 + 32'(i), 32'h10 + 32'(i), 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) step(1'b1, 32'hB000_0000 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step(1'b1, 32'hC000_0000 + 32'(i), 32'h100 + 32'(i), 1'b1, 1'b0);
        step(1'b1, 32'hDEAD_DEAD, 32'h200, 1'b1, 1'b1);
        step(1'b1, 32'hBEEF_0001, 32'h300, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 2; i++) step(1'b1, 32'hE000_0000 + 32'(i), 32'h400 + 32'(i), 1'b1, 1'b0);
        instr_valid_in = 1'b0;
        pipe_stall = 1'b0;
        #2;
        chk("pre_arst_count", 64'(fq_count), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(instr_valid), 64'd0);
        chk("arst_count", 64'(fq_count), 64'd0);
        chk("arst_ready", 64'(fq_ready), 64'd0);
        chk("arst_instr", 64'(instr), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'hF000_0001, 32'h500, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
